// File: rtl/mc_batch_ctrl.sv
// mc_batch_ctrl: runs a programmed batch of simulations, issuing seeds/start pulses and counting y=1 results.
// Optional per-run watchdog enabled by defining MC_TIMEOUT_EN.
module mc_batch_ctrl #(
  parameter int N_RUNS_W  = 16,
  parameter int SEED_W    = 23,
  parameter int TIMEOUT_W = 12
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_go,
  input  logic                i_abort,
  input  logic [N_RUNS_W-1:0] i_n_runs,
  input  logic [SEED_W-1:0]   i_base_seed,
  output logic                o_sim_start,
  output logic [SEED_W-1:0]   o_sim_seed,
  input  logic                i_sim_done,
  input  logic                i_sim_y,
  output logic                o_busy,
  output logic                o_result_valid,
  output logic [N_RUNS_W-1:0] o_hit_count,
  output logic [N_RUNS_W-1:0] o_run_count,
  output logic                o_timeout_err
);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, BLANK = 2'd2, WAIT = 2'd3;
  logic [1:0]          r_state;
  logic [N_RUNS_W-1:0] r_n_runs, r_hit, r_run;
  logic [SEED_W-1:0]   r_base, r_seed;
  logic                r_start, r_busy, r_valid;
  logic [N_RUNS_W-1:0] w_run_nxt, w_hit_nxt;
  logic [SEED_W-1:0]   w_seed_ofs, w_seed_sum, w_seed;
  logic                w_last, w_wd_exp;
  assign w_run_nxt  = r_run + N_RUNS_W'(1);
  assign w_hit_nxt  = r_hit + N_RUNS_W'(i_sim_y);
  assign w_last     = w_run_nxt == r_n_runs;
  // Seed for the run being launched next: first run uses the incoming base, later ones the latched base.
  assign w_seed_ofs = r_state == IDLE ? '0 : SEED_W'(w_run_nxt);
  assign w_seed_sum = (r_state == IDLE ? i_base_seed : r_base) + w_seed_ofs;
  assign w_seed     = w_seed_sum == '0 ? SEED_W'(1) : w_seed_sum;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_n_runs <= '0;
      r_base   <= '0;
      r_hit    <= '0;
      r_run    <= '0;
      r_seed   <= '0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (r_state == IDLE) begin
        if (i_go) begin
          r_n_runs <= i_n_runs;
          r_base   <= i_base_seed;
          r_hit    <= '0;
          r_run    <= '0;
          r_valid  <= i_n_runs == '0;
          r_busy   <= i_n_runs != '0;
          r_start  <= i_n_runs != '0;
          if (i_n_runs != '0) begin
            r_state <= LAUNCH;
            r_seed  <= w_seed;
          end
        end
      end else if (i_abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else if (r_state == LAUNCH) begin
        r_state <= BLANK;
      end else if (r_state == BLANK) begin
        r_state <= WAIT;
      end else if (i_sim_done) begin
        r_hit <= w_hit_nxt;
        r_run <= w_run_nxt;
        if (w_last) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
        end else begin
          r_state <= LAUNCH;
          r_start <= 1'b1;
          r_seed  <= w_seed;
        end
      end else if (w_wd_exp) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end
    end
  end
`ifdef MC_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wd, w_wd_nxt;
  logic                 r_tmo;
  assign w_wd_nxt = r_wd + TIMEOUT_W'(1);
  assign w_wd_exp = r_state == WAIT && !i_sim_done && &w_wd_nxt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wd  <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_wd  <= r_state == LAUNCH ? '0 : (r_state == WAIT && !i_sim_done) ? w_wd_nxt : r_wd;
      r_tmo <= (r_state == IDLE && i_go) ? 1'b0 : (w_wd_exp && !i_abort) ? 1'b1 : r_tmo;
    end
  end
  assign o_timeout_err = r_tmo;
`else
  assign w_wd_exp      = 1'b0;
  assign o_timeout_err = TIMEOUT_W < 0;
`endif
  assign o_sim_start    = r_start;
  assign o_sim_seed     = r_seed;
  assign o_busy         = r_busy;
  assign o_result_valid = r_valid;
  assign o_hit_count    = r_hit;
  assign o_run_count    = r_run;
endmodule

// File: tb/tb_mc_batch_ctrl.sv
// tb_mc_batch_ctrl: scoreboard bench with a behavioural simulation-manager responder and batch-level reference model.
module tb_mc_batch_ctrl;
  localparam int NW = 16, SW = 23, TW = 4;
  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, abort = 1'b0, sim_done = 1'b0, sim_y = 1'b0;
  logic [NW-1:0] n_runs = '0;
  logic [SW-1:0] base_seed = '0;
  logic sim_start, busy, result_valid, timeout_err;
  logic [SW-1:0] sim_seed;
  logic [NW-1:0] hit_count, run_count;
  typedef struct {logic [NW-1:0] hit; logic [NW-1:0] run; logic valid; logic tmo;} res_t;
  int n_vec = 0, n_err = 0;
  logic [SW-1:0] seed_q[$];
  res_t res_q[$];
  int dly_a[64];
  bit y_a[64];
  int stale = 0, starts = 0;
  bit end_req = 1'b0;

  mc_batch_ctrl #(.N_RUNS_W(NW), .SEED_W(SW), .TIMEOUT_W(TW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_abort(abort), .i_n_runs(n_runs),
    .i_base_seed(base_seed), .o_sim_start(sim_start), .o_sim_seed(sim_seed),
    .i_sim_done(sim_done), .i_sim_y(sim_y), .o_busy(busy), .o_result_valid(result_valid),
    .o_hit_count(hit_count), .o_run_count(run_count), .o_timeout_err(timeout_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [SW-1:0] exp_seed(input logic [SW-1:0] base, input int k);
    longint v;
    v = (longint'(base) + longint'(k)) % (longint'(1) << SW);
    return v == 0 ? SW'(1) : SW'(v);
  endfunction

  // Responder: done rises dly cycles after start, y valid with done; optionally keeps the stale done for a few cycles.
  initial begin
    int t = 100000, k;
    forever begin
      @(posedge clk);
      #1;
      if (sim_start) begin
        t = 0;
        starts++;
      end else if (t < 100000) t++;
      k = (starts - 1) & 63;
      if (starts == 0) begin
        sim_done = 1'b0;
        sim_y = 1'($urandom);
      end else if (t < stale) begin
      end else if (t >= dly_a[k]) begin
        sim_done = 1'b1;
        sim_y = y_a[k];
      end else begin
        sim_done = 1'b0;
        sim_y = 1'($urandom);
      end
    end
  end

  initial begin
    logic prev_start = 1'b0;
    logic [SW-1:0] cur = '0;
    res_t r;
    forever begin
      @(negedge clk);
      if (sim_start) begin
        chk("start_gap", 32'(prev_start), 32'd0);
        if (seed_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_start: got seed %0h expected no start", sim_seed);
        end else begin
          cur = seed_q.pop_front();
          chk("seed", 32'(sim_seed), 32'(cur));
        end
      end else if (busy) chk("seed_hold", 32'(sim_seed), 32'(cur));
      prev_start = sim_start;
      if (end_req) begin
        end_req = 1'b0;
        if (res_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL result_q: got empty expected entry");
        end else begin
          r = res_q.pop_front();
          chk("hit_count", 32'(hit_count), 32'(r.hit));
          chk("run_count", 32'(run_count), 32'(r.run));
          chk("result_valid", 32'(result_valid), 32'(r.valid));
          chk("timeout_err", 32'(timeout_err), 32'(r.tmo));
          chk("busy_end", 32'(busy), 32'd0);
          chk("starts_left", 32'(seed_q.size()), 32'd0);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_start"}, 32'(sim_start), 0);
    chk({tag, "_seed"}, 32'(sim_seed), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(result_valid), 0);
    chk({tag, "_hit"}, 32'(hit_count), 0);
    chk({tag, "_run"}, 32'(run_count), 0);
    chk({tag, "_tmo"}, 32'(timeout_err), 0);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 64; k++) begin
      dly_a[k] = $urandom_range(2, 7);
      y_a[k] = 1'($urandom);
    end
  endtask

  // act_at: run index during whose first WAIT cycle an abort (or an ignored go) is applied; -1 for none.
  task automatic run_batch(input int n, input logic [SW-1:0] base, input int st, input int act_at,
                           input bit act_abort, input bit wd);
    res_t r;
    int m, ns, cd;
    bit done_ok;
    m = (act_abort && act_at >= 0) ? act_at : n;
    ns = (act_abort && act_at >= 0) ? act_at + 1 : n;
    if (wd) begin
      m = 0;
      ns = 1;
    end
    for (int k = 0; k < ns; k++) seed_q.push_back(exp_seed(base, k));
    r.hit = '0;
    for (int k = 0; k < m; k++) r.hit += NW'(y_a[k]);
    r.run = NW'(m);
    r.valid = !wd && !(act_abort && act_at >= 0);
    r.tmo = wd;
    res_q.push_back(r);
    stale = st;
    starts = 0;
    n_runs = NW'(n);
    base_seed = base;
    go = 1'b1;
    tick();
    go = 1'b0;
    n_runs = NW'($urandom);
    base_seed = SW'($urandom);
    cd = -1;
    done_ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (!busy) begin
        done_ok = 1'b1;
        break;
      end
      if (sim_start && act_at >= 0 && starts == act_at + 1) cd = 2;
      if (cd == 0) begin
        if (act_abort) abort = 1'b1;
        else begin
          go = 1'b1;
          n_runs = NW'($urandom);
          base_seed = SW'($urandom);
        end
      end
      tick();
      abort = 1'b0;
      go = 1'b0;
      if (cd >= 0) cd--;
    end
    if (!done_ok) begin
      n_vec++;
      n_err++;
      $display("FAIL batch_timeout: got busy=1 after 5000 cycles expected completion");
    end
    end_req = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, act, st;
    bit ab;
    logic [SW-1:0] b;
    rst_n = 1'b0;
    repeat (2) tick();
    check_zero("reset");
    rst_n = 1'b1;
    repeat (20) tick();
    chk("idle_starts", 32'(starts), 0);
    for (int k = 0; k < 64; k++) dly_a[k] = 5;
    y_a[0] = 1; y_a[1] = 0; y_a[2] = 1; y_a[3] = 1;
    run_batch(4, 23'h0C, 0, -1, 0, 0);
    for (int k = 0; k < 64; k++) begin
      dly_a[k] = 4;
      y_a[k] = 0;
    end
    run_batch(2, 23'h7FFFFF, 2, -1, 0, 0);
    run_batch(0, 23'h55, 0, -1, 0, 0);
    fill_rand();
    for (int k = 0; k < 64; k++) dly_a[k] = 4;
    run_batch(10, 23'h1234, 0, 2, 1, 0);
    fill_rand();
    for (int k = 0; k < 64; k++) dly_a[k] = 4;
    run_batch(3, 23'h40, 1, 1, 0, 0);
`ifdef MC_TIMEOUT_EN
    for (int k = 0; k < 64; k++) dly_a[k] = 1 << 30;
    run_batch(5, 23'h77, 0, -1, 0, 1);
`endif
    for (int i = 0; i < 40; i++) begin
      fill_rand();
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      b = ($urandom_range(0, 2) == 0) ? SW'(23'h7FFFF8 + $urandom_range(0, 7)) : SW'($urandom);
      st = $urandom_range(0, 2);
      act = -1;
      ab = 1'b0;
      if (n > 0 && $urandom_range(0, 99) < 40) begin
        act = $urandom_range(0, n - 1);
        ab = $urandom_range(0, 99) < 60;
        dly_a[act] = $urandom_range(3, 7);
      end
      run_batch(n, b, st, act, ab, 0);
    end
    fill_rand();
    stale = 0;
    starts = 0;
    n_runs = 5;
    base_seed = 23'h100;
    for (int k = 0; k < 5; k++) seed_q.push_back(exp_seed(23'h100, k));
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    go = 1'b1;
    abort = 1'b1;
    repeat (2) tick();
    check_zero("rst_mid");
    rst_n = 1'b1;
    go = 1'b0;
    abort = 1'b0;
    seed_q.delete();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
